// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and helpers for the ID-stage hazard tracker
package pipe_hazard_pkg;

  // Slot register fields are sized for the widest supported register file;
  // narrower address widths are zero-extended on entry.
  localparam int RN_MAX = 8;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic [RN_MAX-1:0] rn;
    logic              st_late;
  } slot_t;

  function automatic int fw_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// rtl/pipe_hazard_match.sv - priority match of one source operand against the in-flight slots
module pipe_hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FW    = fw_width(DEPTH)
) (
  input  slot_t             slots [DEPTH],
  input  logic [RN_MAX-1:0] src,
  input  logic              use_src,
  output logic              hit,
  output logic [FW-1:0]     idx,
  output logic              load_pend
);

  // Scan from the oldest slot down so the youngest matching writer wins.
  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    load_pend = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_src && (src != '0) && slots[k].valid && slots[k].wreg &&
          (slots[k].rn == src)) begin
        hit       = 1'b1;
        idx       = FW'(k);
        load_pend = slots[k].m2reg;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - in-flight destination tracker producing forwarding selects and load-use stalls
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int RW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CW         = 16,
  parameter int FW         = fw_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_is_store,
  output logic          stall,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic          mem_store_late,
  output logic [CW-1:0] stall_count
);

  slot_t slots [DEPTH];

  logic          hit_a, hit_b;
  logic [FW-1:0] idx_a, idx_b;
  logic          ld_a, ld_b;

  pipe_hazard_match #(.DEPTH(DEPTH), .FW(FW)) u_match_rs (
    .slots     (slots),
    .src       (RN_MAX'(id_rs)),
    .use_src   (id_use_rs),
    .hit       (hit_a),
    .idx       (idx_a),
    .load_pend (ld_a)
  );

  pipe_hazard_match #(.DEPTH(DEPTH), .FW(FW)) u_match_rt (
    .slots     (slots),
    .src       (RN_MAX'(id_rt)),
    .use_src   (id_use_rt),
    .hit       (hit_b),
    .idx       (idx_b),
    .load_pend (ld_b)
  );

  logic  load_early_a, load_early_b;
  logic  late_ok_b;
  logic  haz_a, haz_b;
  logic  st_late_b;
  logic  take_id;
  slot_t id_rec;

  always_comb begin
    load_early_a = hit_a && ld_a && (int'(idx_a) < LOAD_STAGE);
    load_early_b = hit_b && ld_b && (int'(idx_b) < LOAD_STAGE);
    // Store data may be picked up one stage later than an ALU operand.
    late_ok_b    = id_is_store && ((int'(idx_b) + 1) >= LOAD_STAGE);
    haz_a        = load_early_a;
    haz_b        = load_early_b && !late_ok_b;
    st_late_b    = load_early_b && late_ok_b;

    stall   = id_valid && !flush && (haz_a || haz_b);
    take_id = id_valid && !stall && !flush;

    fwd_a = hit_a ? FW'(idx_a + FW'(1)) : FW'(FWD_RF);
    fwd_b = hit_b ? FW'(idx_b + FW'(1)) : FW'(FWD_RF);

    id_rec         = '0;
    id_rec.valid   = 1'b1;
    id_rec.wreg    = id_wreg;
    id_rec.m2reg   = id_m2reg;
    id_rec.rn      = RN_MAX'(id_rn);
    id_rec.st_late = st_late_b;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slots[k] <= '0;
      end
      stall_count <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slots[k] <= slots[k-1];
      end
      slots[0] <= take_id ? id_rec : '0;
      if (stall && (stall_count != {CW{1'b1}})) begin
        stall_count <= stall_count + CW'(1);
      end
    end
  end

  assign mem_store_late = slots[1].valid && slots[1].st_late;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  logic        clock;
  logic        reset;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic        id_wreg;
  logic        id_m2reg;
  logic [4:0]  id_rn;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_is_store;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_store_late;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  pipe_hazard_unit dut (
    .clock          (clock),
    .reset          (reset),
    .hold           (hold),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_wreg        (id_wreg),
    .id_m2reg       (id_m2reg),
    .id_rn          (id_rn),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_is_store    (id_is_store),
    .stall          (stall),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .mem_store_late (mem_store_late),
    .stall_count    (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic w, input logic m, input logic [4:0] rn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic st);
    id_valid    = v;
    id_wreg     = w;
    id_m2reg    = m;
    id_rn       = rn;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_is_store = st;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_msl", mem_store_late, 0);
    chk("rst_count", stall_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // ALU chain: producer of r3 followed by four readers
    set_id(1, 1, 0, 3, 0, 0, 0, 0, 0);
    chk("alu_prod_stall", stall, 0);
    tick();
    set_id(1, 0, 0, 0, 3, 0, 1, 0, 0);
    chk("alu_fwd1", fwd_a, 1);
    chk("alu_stall1", stall, 0);
    tick();
    chk("alu_fwd2", fwd_a, 2);
    tick();
    chk("alu_fwd3", fwd_a, 3);
    tick();
    chk("alu_fwd0", fwd_a, 0);
    chk("alu_stall4", stall, 0);
    tick();

    // Load-use on rs
    set_id(1, 1, 1, 5, 0, 0, 0, 0, 0);
    chk("lu_load_stall", stall, 0);
    tick();
    set_id(1, 1, 0, 6, 5, 0, 1, 0, 0);
    chk("lu_stall", stall, 1);
    chk("lu_fwd_ex", fwd_a, 1);
    tick();
    chk("lu_fwd_mem", fwd_a, 2);
    chk("lu_stall_clear", stall, 0);
    chk("lu_count", stall_count, 1);
    tick();
    chk("lu_count_after", stall_count, 1);

    // Store data from the load just ahead of it
    set_id(1, 1, 1, 3, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 3, 0, 1, 1);
    chk("st_stall", stall, 0);
    chk("st_fwd_b", fwd_b, 1);
    chk("st_msl_pre", mem_store_late, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("st_msl_ex", mem_store_late, 0);
    tick();
    chk("st_msl_mem", mem_store_late, 1);
    tick();
    chk("st_msl_wb", mem_store_late, 0);
    chk("st_count", stall_count, 1);

    // Non-store use of a load on rt stalls; flush suppresses it
    set_id(1, 1, 1, 7, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 1, 0, 8, 0, 7, 0, 1, 0);
    chk("rt_stall", stall, 1);
    chk("rt_fwd_b", fwd_b, 1);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_count", stall_count, 1);
    chk("flush_fwd_b", fwd_b, 2);
    chk("flush_restall", stall, 0);
    tick();

    // Priority between two writers of r4, and register 0
    set_id(1, 1, 0, 4, 0, 0, 0, 0, 0);
    tick();
    tick();
    set_id(1, 0, 0, 0, 4, 0, 1, 0, 0);
    chk("prio_fwd", fwd_a, 1);
    set_id(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("r0_fwd", fwd_a, 0);
    set_id(1, 0, 0, 0, 4, 0, 0, 0, 0);
    chk("nouse_fwd", fwd_a, 0);
    set_id(1, 0, 0, 0, 4, 0, 1, 0, 0);
    chk("prio_fwd_mem", fwd_a, 2);
    tick();

    // Hold during a load-use stall
    set_id(1, 1, 1, 10, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 10, 0, 1, 0, 0);
    chk("hold_pre_stall", stall, 1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stall", stall, 1);
      chk("hold_fwd", fwd_a, 1);
      chk("hold_count", stall_count, 1);
    end
    hold = 1'b0;
    tick();
    chk("resume_count", stall_count, 2);
    chk("resume_fwd", fwd_a, 2);
    chk("resume_stall", stall, 0);

    // Asynchronous reset in the middle of a stall
    set_id(1, 1, 1, 11, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 11, 0, 1, 0, 0);
    chk("mid_stall", stall, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_fwd_a", fwd_a, 0);
    chk("arst_fwd_b", fwd_b, 0);
    chk("arst_msl", mem_store_late, 0);
    chk("arst_count", stall_count, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding tracker for the ID stage of the pipelined CPU. It is the successor to the fixed EX/MEM-compare logic in the ID control unit. It keeps a shift register of in-flight destination records for DEPTH downstream stages. Each cycle it produces per-operand forwarding selects, a load-use stall, and a late-store-data flag that travels with the store. It also counts stall cycles.

## Interface
- RW, 5: register address width.
- DEPTH, 3: number of tracked downstream slots. Slot 0 = EX, 1 = MEM, 2 = WB, and so on. Legal range 2..7.
- LOAD_STAGE, 1: first slot index at which a load result is forwardable. Legal range 1..DEPTH-1.
- CW, 16: stall counter width.
- Derived constant FW = $clog2(DEPTH+1): forwarding select width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- hold  in  1  freeze the whole tracker (memory wait).
- flush  in  1  kill the instruction currently in ID.
- id_valid  in  1  ID holds a real instruction.
- id_wreg  in  1  ID instruction writes a register.
- id_m2reg  in  1  ID instruction is a load.
- id_rn  in  RW  ID destination register.
- id_rs  in  RW  ID source register A.
- id_rt  in  RW  ID source register B.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_is_store  in  1  rt is store data, not an ALU operand.
- stall  out  1  hold PC/IF/ID; a bubble is inserted into EX.
- fwd_a  out  FW  0 = register file; k+1 = result of slot k.
- fwd_b  out  FW  same encoding, for rt.
- mem_store_late  out  1  the store now in MEM takes its data from the WB result.
- stall_count  out  CW  saturating count of stall cycles.

## Operation
- Slot record: valid, wreg, m2reg, rn, st_late.
- A slot k matches source s when valid & wreg & rn==s & s!=0 & use_s. Only the lowest-k matching slot is considered; lower k has priority. Register 0 never forwards.
- fwd_x = k+1 for the winning slot, else 0.
- Load hazard on operand s, winning slot k with m2reg=1 and k < LOAD_STAGE:
  - Operand A, or operand B when not a store: stall=1.
  - Operand B when id_is_store=1 and k+1 >= LOAD_STAGE: no stall. The store's st_late bit is set; its data is resolved one stage later.
  - Operand B when id_is_store=1 and k+1 < LOAD_STAGE: stall=1.
- stall = id_valid & !flush & any hazard. flush forces stall=0.
- Shift rules on the clock edge, when hold=0:
  - Slot k+1 takes slot k.
  - Slot 0 takes the ID record if id_valid & !stall & !flush; otherwise slot 0 takes a bubble (valid=0).
  - The last slot is discarded.
- hold=1: no slot changes and the counter does not change. Outputs keep being recomputed combinationally from the frozen slots and the current ID inputs.
- mem_store_late = slot1.valid & slot1.st_late. It is a registered value: it is driven straight from slot state.
- stall_count increments on each edge where stall=1 & hold=0. It saturates at 2^CW-1.

## Timing
- stall, fwd_a and fwd_b are combinational from the ID inputs and slot state. There is no added latency.
- An instruction accepted in ID at cycle n:
  - occupies slot 0 at n+1 and slot k at n+1+k;
  - is untracked from n+1+DEPTH.
- A stall lasts (LOAD_STAGE - k) cycles for a load in slot k. The stalled instruction re-evaluates every cycle.
- Reset, asynchronous, at any time including mid-stall or during hold:
  - all slots invalid, stall_count=0;
  - hence stall=0, fwd_a=fwd_b=0, mem_store_late=0 immediately.
- Simultaneous events:
  - flush with hazard: bubble, no stall, no count.
  - hold with flush: hold wins and nothing is captured.
  - hold with stall: stall is visible but not counted.

## Structure
- Package pipe_hazard_pkg holds:
  - the slot record typedef;
  - the FWD_RF=0 constant;
  - a function for FW.
- Sub-module pipe_hazard_match: one operand's priority match over DEPTH slots. It outputs hit, the slot index, and the load-pending flag. It is instantiated twice, for rs and for rt.
- Top level holds the slot shift register, the stall/store-late decision, and the counter. Target size is about 200 lines.

## Test plan
All scenarios use the default parameters.
- Reset: assert reset while slots are full and a stall is active -> stall=0, fwd_a=fwd_b=0, mem_store_late=0, stall_count=0 within the same cycle.
- ALU chain: cycle n, add with rn=3. Cycles n+1..n+4, rs=3 with use_rs -> fwd_a = 1, 2, 3, 0. stall stays 0.
- Load-use: lw with rn=5, then rs=5 -> stall=1 for exactly one cycle and a bubble enters EX. The next cycle gives fwd_a=2, stall=0, stall_count=1.
- Store after load: lw with rn=3, then sw with rt=3, id_is_store=1 -> stall=0 and fwd_b=1. mem_store_late=1 for exactly one cycle, two edges after the store is accepted.
- Priority and r0: slots 0 and 1 both write 4 -> fwd_a=1. A source of rs=0 matching an rn=0 writer -> fwd_a=0.
- Flush/hold:
  - flush during a load-use hazard -> stall=0 and stall_count unchanged;
  - hold for 3 cycles -> slot contents, fwd outputs and count unchanged, then normal shifting resumes.
